// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, drives instr_mem and registers the fetched
// word into a valid/ready IF/ID output register with redirect flush.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    input  logic        ready_d,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_f_r;
    logic [31:0] instr_d_r;
    logic [31:0] pc_d_r;
    logic [31:0] pcplus4_d_r;
    logic        valid_d_r;
    logic        misalign_err_r;
    logic [31:0] fetch_count_r;

    logic        adv_s;
    logic        take_s;
    logic [31:0] pc_f_nxt_s;
    logic [31:0] instr_d_nxt_s;
    logic [31:0] pc_d_nxt_s;
    logic [31:0] pcplus4_d_nxt_s;
    logic        valid_d_nxt_s;
    logic        misalign_err_nxt_s;
    logic [31:0] fetch_count_nxt_s;

    assign adv_s  = !valid_d_r || ready_d;
    assign take_s = valid_d_r && ready_d;

    // Next-state selection: redirect beats advance, advance beats stall.
    always_comb begin
        pc_f_nxt_s         = pc_f_r;
        instr_d_nxt_s      = instr_d_r;
        pc_d_nxt_s         = pc_d_r;
        pcplus4_d_nxt_s    = pcplus4_d_r;
        valid_d_nxt_s      = valid_d_r;
        misalign_err_nxt_s = misalign_err_r;
        if (redirect) begin
            pc_f_nxt_s    = {redirect_target[31:2], 2'b00};
            valid_d_nxt_s = 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_err_nxt_s = 1'b1;
            end else begin
                misalign_err_nxt_s = misalign_err_r;
            end
        end else if (adv_s) begin
            instr_d_nxt_s   = imem_rd;
            pc_d_nxt_s      = pc_f_r;
            pcplus4_d_nxt_s = pc_f_r + 32'd4;
            valid_d_nxt_s   = 1'b1;
            pc_f_nxt_s      = pc_f_r + 32'd4;
        end else begin
            pc_f_nxt_s    = pc_f_r;
            valid_d_nxt_s = valid_d_r;
        end
    end

    // Hand-off counter runs on every consumed output, even when flushed the same edge.
    always_comb begin
        fetch_count_nxt_s = fetch_count_r;
        if (take_s) begin
            fetch_count_nxt_s = fetch_count_r + 32'd1;
        end else begin
            fetch_count_nxt_s = fetch_count_r;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f_r         <= RESET_PC;
            instr_d_r      <= 32'h0000_0000;
            pc_d_r         <= 32'h0000_0000;
            pcplus4_d_r    <= 32'h0000_0000;
            valid_d_r      <= 1'b0;
            misalign_err_r <= 1'b0;
            fetch_count_r  <= 32'h0000_0000;
        end else begin
            pc_f_r         <= pc_f_nxt_s;
            instr_d_r      <= instr_d_nxt_s;
            pc_d_r         <= pc_d_nxt_s;
            pcplus4_d_r    <= pcplus4_d_nxt_s;
            valid_d_r      <= valid_d_nxt_s;
            misalign_err_r <= misalign_err_nxt_s;
            fetch_count_r  <= fetch_count_nxt_s;
        end
    end

    assign imem_a       = pc_f_r;
    assign instr_d      = instr_d_r;
    assign pc_d         = pc_d_r;
    assign pcplus4_d    = pcplus4_d_r;
    assign valid_d      = valid_d_r;
    assign misalign_err = misalign_err_r;
    assign fetch_count  = fetch_count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// phase scored against a stream-level model of the expected instruction sequence.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] imem_a;
    logic [31:0] imem_rd;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        ready_d;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_checks;
    int n_pass;
    logic [31:0] exp_cnt;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_a(imem_a), .imem_rd(imem_rd),
        .redirect(redirect), .redirect_target(redirect_target),
        .instr_d(instr_d), .pc_d(pc_d), .pcplus4_d(pcplus4_d),
        .valid_d(valid_d), .ready_d(ready_d),
        .misalign_err(misalign_err), .fetch_count(fetch_count)
    );

    // Instruction memory image: three fixed words, a scrambled address elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h0050_0113;
            32'h0000_0004: mem_word = 32'h00C0_0193;
            32'h0000_0008: mem_word = 32'hFF71_8393;
            default:       mem_word = {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    assign imem_rd = mem_word(imem_a);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (valid_d !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid_d); else n_pass++;
        n_checks++; if (imem_a !== 32'h0) $display("FAIL reset_imem_a: got %h want 00000000", imem_a); else n_pass++;
        n_checks++; if (instr_d !== 32'h0 || pc_d !== 32'h0 || pcplus4_d !== 32'h0) $display("FAIL reset_outputs: got %h/%h/%h want 0/0/0", instr_d, pc_d, pcplus4_d); else n_pass++;
        n_checks++; if (fetch_count !== 32'h0 || misalign_err !== 1'b0) $display("FAIL reset_cnt_err: got %h/%0b want 0/0", fetch_count, misalign_err); else n_pass++;
        step();
        reset = 1'b0;
        exp_cnt = 32'd0;
    endtask

    task automatic test_stream();
        step();
        n_checks++; if (valid_d !== 1'b1 || instr_d !== 32'h0050_0113 || pc_d !== 32'h0 || pcplus4_d !== 32'h4) $display("FAIL stream_e1: got v=%0b %h pc=%h p4=%h want v=1 00500113 pc=0 p4=4", valid_d, instr_d, pc_d, pcplus4_d); else n_pass++;
        step();
        n_checks++; if (instr_d !== 32'h00C0_0193 || pc_d !== 32'h4 || pcplus4_d !== 32'h8) $display("FAIL stream_e2: got %h pc=%h p4=%h want 00c00193 pc=4 p4=8", instr_d, pc_d, pcplus4_d); else n_pass++;
        step();
        exp_cnt = 32'd2;
        n_checks++; if (instr_d !== 32'hFF71_8393 || pc_d !== 32'h8) $display("FAIL stream_e3: got %h pc=%h want ff718393 pc=8", instr_d, pc_d); else n_pass++;
        n_checks++; if (fetch_count !== exp_cnt) $display("FAIL stream_count: got %0d want %0d", fetch_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_stall();
        redirect = 1'b1; redirect_target = 32'h4; ready_d = 1'b0;
        step();
        redirect = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (valid_d !== 1'b1 || instr_d !== 32'h00C0_0193 || pc_d !== 32'h4 || imem_a !== 32'h8) $display("FAIL stall_hold%0d: got v=%0b %h pc=%h a=%h want v=1 00c00193 pc=4 a=8", i, valid_d, instr_d, pc_d, imem_a); else n_pass++;
            n_checks++; if (fetch_count !== exp_cnt) $display("FAIL stall_count%0d: got %0d want %0d", i, fetch_count, exp_cnt); else n_pass++;
        end
        ready_d = 1'b1;
        step();
        exp_cnt = exp_cnt + 32'd1;
        n_checks++; if (pc_d !== 32'h8 || fetch_count !== exp_cnt) $display("FAIL stall_release: got pc=%h cnt=%0d want pc=8 cnt=%0d", pc_d, fetch_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_redirect_flush();
        ready_d = 1'b0; redirect = 1'b1; redirect_target = 32'h20;
        step();
        redirect = 1'b0;
        n_checks++; if (valid_d !== 1'b0 || imem_a !== 32'h20) $display("FAIL flush_bubble: got v=%0b a=%h want v=0 a=20", valid_d, imem_a); else n_pass++;
        step();
        n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'h20 || instr_d !== mem_word(32'h20)) $display("FAIL flush_target: got v=%0b pc=%h %h want v=1 pc=20 %h", valid_d, pc_d, instr_d, mem_word(32'h20)); else n_pass++;
        n_checks++; if (fetch_count !== exp_cnt) $display("FAIL flush_count: got %0d want %0d", fetch_count, exp_cnt); else n_pass++;
    endtask

    task automatic test_redirect_take();
        ready_d = 1'b1; redirect = 1'b1; redirect_target = 32'h40;
        step();
        redirect = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        n_checks++; if (valid_d !== 1'b0 || fetch_count !== exp_cnt || imem_a !== 32'h40) $display("FAIL take_redir: got v=%0b cnt=%0d a=%h want v=0 cnt=%0d a=40", valid_d, fetch_count, imem_a, exp_cnt); else n_pass++;
        step();
        n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'h40 || misalign_err !== 1'b0) $display("FAIL take_target: got v=%0b pc=%h err=%0b want v=1 pc=40 err=0", valid_d, pc_d, misalign_err); else n_pass++;
    endtask

    task automatic test_misalign();
        redirect = 1'b1; redirect_target = 32'h46;
        step();
        redirect = 1'b0;
        exp_cnt = exp_cnt + 32'd1;
        n_checks++; if (misalign_err !== 1'b1 || imem_a !== 32'h44) $display("FAIL misalign_set: got err=%0b a=%h want err=1 a=44", misalign_err, imem_a); else n_pass++;
        step();
        exp_cnt = exp_cnt;
        n_checks++; if (misalign_err !== 1'b1 || pc_d !== 32'h44 || pcplus4_d !== 32'h48) $display("FAIL misalign_sticky: got err=%0b pc=%h p4=%h want err=1 pc=44 p4=48", misalign_err, pc_d, pcplus4_d); else n_pass++;
        step();
        exp_cnt = exp_cnt + 32'd1;
        n_checks++; if (misalign_err !== 1'b1 || fetch_count !== exp_cnt) $display("FAIL misalign_hold: got err=%0b cnt=%0d want err=1 cnt=%0d", misalign_err, fetch_count, exp_cnt); else n_pass++;
    endtask

    // Random ready/redirect traffic; the model tracks only the PC expected at the head of the stream.
    task automatic test_random();
        logic [31:0] head;
        logic        m_valid;
        logic        rdy;
        logic        rdr;
        logic [31:0] tgt;
        logic [31:0] rnd;
        int          errs;
        errs = 0;
        ready_d = 1'b0; redirect = 1'b1; redirect_target = 32'h100;
        step();
        head = 32'h100; m_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rdr = ($urandom_range(0, 11) == 0);
            rnd = $urandom;
            tgt = (rnd[3] == 1'b1) ? (rnd & 32'h0000_0FFC) : rnd;
            ready_d = rdy; redirect = rdr; redirect_target = tgt;
            step();
            if (m_valid && rdy) exp_cnt = exp_cnt + 32'd1;
            if (rdr) head = tgt & 32'hFFFF_FFFC;
            else if (m_valid && rdy) head = head + 32'd4;
            m_valid = !rdr;
            n_checks++; if (valid_d !== m_valid || imem_a !== (m_valid ? head + 32'd4 : head) || fetch_count !== exp_cnt || misalign_err !== 1'b1) begin
                $display("FAIL rand_ctrl%0d: got v=%0b a=%h cnt=%0d err=%0b want v=%0b head=%h cnt=%0d err=1", i, valid_d, imem_a, fetch_count, misalign_err, m_valid, head, exp_cnt);
                errs++;
            end else n_pass++;
            if (m_valid) begin
                n_checks++; if (pc_d !== head || instr_d !== mem_word(head) || pcplus4_d !== head + 32'd4) begin
                    $display("FAIL rand_data%0d: got pc=%h %h p4=%h want pc=%h %h p4=%h", i, pc_d, instr_d, pcplus4_d, head, mem_word(head), head + 32'd4);
                    errs++;
                end else n_pass++;
            end
            if (errs > 10) break;
        end
        redirect = 1'b0; ready_d = 1'b1;
    endtask

    task automatic test_wrap_async_reset();
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFC; ready_d = 1'b1;
        step();
        redirect = 1'b0;
        step();
        n_checks++; if (pc_d !== 32'hFFFF_FFFC || pcplus4_d !== 32'h0 || imem_a !== 32'h0) $display("FAIL wrap_top: got pc=%h p4=%h a=%h want fffffffc/0/0", pc_d, pcplus4_d, imem_a); else n_pass++;
        step();
        n_checks++; if (pc_d !== 32'h0 || pcplus4_d !== 32'h4 || instr_d !== 32'h0050_0113) $display("FAIL wrap_zero: got pc=%h p4=%h %h want 0/4/00500113", pc_d, pcplus4_d, instr_d); else n_pass++;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (valid_d !== 1'b0 || imem_a !== 32'h0 || fetch_count !== 32'h0 || misalign_err !== 1'b0 || pc_d !== 32'h0) $display("FAIL async_reset: got v=%0b a=%h cnt=%0d err=%0b pc=%h want 0/0/0/0/0", valid_d, imem_a, fetch_count, misalign_err, pc_d); else n_pass++;
        step();
        reset = 1'b0;
        step();
        n_checks++; if (valid_d !== 1'b1 || pc_d !== 32'h0 || instr_d !== 32'h0050_0113 || fetch_count !== 32'h0) $display("FAIL post_reset: got v=%0b pc=%h %h cnt=%0d want v=1 pc=0 00500113 cnt=0", valid_d, pc_d, instr_d, fetch_count); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        exp_cnt = 32'd0;
        reset = 1'b1;
        redirect = 1'b0;
        redirect_target = 32'h0;
        ready_d = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_flush();
        test_redirect_take();
        test_misalign();
        test_random();
        test_wrap_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- PC-generation and fetch stage directly upstream of instr_mem.
- Holds the fetch PC and drives it on the instr_mem address port. instr_mem read data is combinational and returns the same cycle.
- The fetched word, its PC and PC+4 are registered into an IF/ID output register, which feeds decode through a valid/ready handshake.
- Accepts a redirect (taken branch/jump) that flushes the output register and reloads the PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_a  output  32  instruction memory address; combinationally equal to pc_f.
- imem_rd  input  32  instruction word from instr_mem for imem_a, valid same cycle.
- redirect  input  1  taken branch/jump from execute; flush and reload PC.
- redirect_target  input  32  new PC when redirect=1.
- instr_d  output  32  registered instruction to decode.
- pc_d  output  32  PC of instr_d.
- pcplus4_d  output  32  pc_d+4, modulo 2^32.
- valid_d  output  1  instr_d/pc_d/pcplus4_d hold a live instruction.
- ready_d  input  1  decode accepts the current output this cycle.
- misalign_err  output  1  sticky; set when a redirect target has bits [1:0] != 0.
- fetch_count  output  32  number of instructions handed to decode (valid_d & ready_d edges), wraps modulo 2^32.

Behaviour:
- Reset, asynchronous, immediate on assertion:
  - pc_f = RESET_PC, so imem_a = RESET_PC.
  - instr_d = 0, pc_d = 0, pcplus4_d = 0, valid_d = 0.
  - misalign_err = 0, fetch_count = 0.
- Reset mid-operation discards any pending output. First valid_d=1 appears on the first rising edge after reset deasserts, with pc_d = RESET_PC.
- Define:
  - adv = !valid_d | ready_d (output register free or being consumed).
  - take = valid_d & ready_d.
- Priority per rising edge, highest first:
  1. redirect=1:
     - pc_f <= {redirect_target[31:2], 2'b00}; valid_d <= 0; other output registers hold.
     - If redirect_target[1:0] != 0, misalign_err <= 1.
     - If take=1 in the same cycle, fetch_count still increments (decode consumed it).
  2. adv=1 (no redirect):
     - instr_d <= imem_rd; pc_d <= pc_f; pcplus4_d <= pc_f+4; valid_d <= 1; pc_f <= pc_f+4.
  3. Otherwise (valid_d=1, ready_d=0), stall: pc_f and all output registers hold.
- fetch_count increments by 1 on every edge where take=1, independent of redirect. It wraps from 32'hFFFF_FFFF to 0.
- misalign_err is cleared only by reset.
- Latency:
  - Redirect to the first valid_d of the target: 1 edge after the redirect edge, so valid_d=0 for exactly one cycle.
  - Sustained throughput with ready_d=1: one instruction per cycle.
- PC arithmetic: all 32-bit unsigned, wrap-around. pc_f = 32'hFFFF_FFFC fetches, then pc_f becomes 0 and pcplus4_d = 0.
- While valid_d=1 and ready_d=0, outputs stay stable. imem_a stays equal to pc_f, which is the next PC, not pc_d.
- No combinational path from ready_d or redirect to any output. imem_a depends only on pc_f.

Test Plan:
- Reset and stream:
  - Stimulus: instr_mem preloaded with 0x00500113@0, 0x00C00193@4, 0xFF718393@8; ready_d=1; release reset.
  - Required: edge 1 gives valid_d=1, instr_d=0x00500113, pc_d=0, pcplus4_d=4. Edges 2 and 3 give the words at 4 and 8. fetch_count=2 after edge 3.
- Stall:
  - Stimulus: hold ready_d=0 for 3 cycles with pc_d=4.
  - Required: instr_d=0x00C00193, pc_d=4 and imem_a=8 stay constant; fetch_count unchanged. On ready_d=1, the next edge delivers pc_d=8.
- Redirect with flush:
  - Stimulus: redirect=1, redirect_target=0x20, for one cycle while valid_d=1 and ready_d=0.
  - Required: next cycle valid_d=0 and imem_a=0x20; the following edge gives pc_d=0x20. The flushed instruction is never counted.
- Redirect concurrent with take:
  - Stimulus: valid_d=1, ready_d=1, redirect=1 to 0x40.
  - Required: fetch_count+1, valid_d=0 next cycle, then pc_d=0x40.
- Misaligned redirect:
  - Stimulus: redirect_target=0x46.
  - Required: misalign_err=1 and stays 1, imem_a=0x44. Only reset clears it.
- Wrap and async reset:
  - Stimulus: redirect to 0xFFFF_FFFC, then step 2 edges.
  - Required: pc_d=0xFFFF_FFFC with pcplus4_d=0, then pc_d=0.
  - Then assert reset mid-cycle. Required: valid_d=0, imem_a=RESET_PC and fetch_count=0 immediately, before the next clock edge.
